// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder stage plus a carry flop processes
// WIDTH-bit operands LSB-first, one bit per clock, behind a start/busy/done
// handshake. Result and carry are registered and held until the next operation
// completes.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   start  request pulse, accepted in IDLE or DONE
//   sub    0: a+b+cin, 1: a-b (a + ~b + 1, cin ignored); captured with start
//   a, b   operands, captured on the accepting edge
//   cin    carry-in for add mode, captured on the accepting edge
//   busy   high while a serial operation is in progress
//   done   one-cycle pulse marking a completed result
//   s      registered sum/difference
//   c      registered carry-out (add) or no-borrow flag (sub: 1 means a>=b)
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c
);

    // Counter only needs to reach WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             bit_c;
    logic             carry_c;
    logic [WIDTH-1:0] res_c;

    // Single shared full-adder cell and the result shift-in value.
    always_comb begin
        bit_c   = sa[0] ^ sb[0] ^ carry;
        carry_c = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
        // Shift-in at MSB written without part-selects so WIDTH=1 stays legal.
        res_c   = (res >> 1) | (WIDTH'(bit_c) << (WIDTH - 1));
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            c     <= 1'b0;
        end else begin
            case (state)
                // DONE accepts a new start exactly like IDLE (back-to-back).
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        res   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end

                RUN: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    res   <= res_c;
                    carry <= carry_c;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        s     <= res_c;
                        c     <= carry_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder: WIDTH=8 and WIDTH=1 instances.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, c8;
    logic [7:0] s8;

    logic start1 = 1'b0, sub1 = 1'b0, cin1 = 1'b0;
    logic a1 = 1'b0, b1 = 1'b0;
    logic busy1, done1, c1, s1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .cin(cin8), .busy(busy8), .done(done8), .s(s8), .c(c8)
    );

    serial_adder #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1),
        .cin(cin1), .busy(busy1), .done(done1), .s(s1), .c(c1)
    );

    task automatic check_eq(input string tag, input logic [63:0] observed,
                            input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start pulse on the 8-bit unit; returns after the accepting edge.
    task automatic go8(input logic [7:0] ta, input logic [7:0] tb, input logic tcin,
                       input logic tsub);
        a8 = ta; b8 = tb; cin8 = tcin; sub8 = tsub; start8 = 1'b1;
        tick();
        start8 = 1'b0;
    endtask

    // Count busy cycles (bounded) after acceptance, then check the done cycle.
    task automatic finish8(input string tag, input logic [7:0] es, input logic ec);
        int n = 0;
        while (busy8 && n < 100) begin
            tick();
            n++;
        end
        check_eq({tag, "_busy_cycles"}, 64'(n), 64'd8);
        check_eq({tag, "_done"}, 64'(done8), 64'd1);
        check_eq({tag, "_s"}, 64'(s8), 64'(es));
        check_eq({tag, "_c"}, 64'(c8), 64'(ec));
    endtask

    task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic tcin, input logic tsub, input logic [7:0] es,
                       input logic ec);
        go8(ta, tb, tcin, tsub);
        check_eq({tag, "_busy_start"}, 64'(busy8), 64'd1);
        finish8(tag, es, ec);
        tick();
        check_eq({tag, "_done_pulse_end"}, 64'(done8), 64'd0);
    endtask

    initial begin
        int seen_done;
        logic [1:0] fa;

        // Reset state
        #12;
        check_eq("rst_busy", 64'(busy8), 64'd0);
        check_eq("rst_done", 64'(done8), 64'd0);
        check_eq("rst_s", 64'(s8), 64'd0);
        check_eq("rst_c", 64'(c8), 64'd0);
        rst_n = 1'b1;
        tick();

        // Add with wrap: FF + 01 = 00 carry 1
        op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);

        // Subtract both ways
        op8("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0);
        op8("sub_07_05", 8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1);

        // Re-pulsed start during RUN is ignored; s holds previous result meanwhile
        go8(8'h10, 8'h20, 1'b1, 1'b0);
        tick();
        tick();
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0; sub8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check_eq("ign_s_hold", 64'(s8), 64'h02);
        check_eq("ign_busy", 64'(busy8), 64'd1);
        begin
            int n = 3;
            while (busy8 && n < 100) begin
                tick();
                n++;
            end
            check_eq("ign_busy_cycles", 64'(n), 64'd8);
        end
        check_eq("ign_done", 64'(done8), 64'd1);
        check_eq("ign_s", 64'(s8), 64'h31);
        check_eq("ign_c", 64'(c8), 64'd0);
        tick();

        // Back-to-back: start held in the done cycle
        go8(8'h03, 8'h04, 1'b0, 1'b0);
        finish8("b2b_first", 8'h07, 1'b0);
        go8(8'h01, 8'h01, 1'b0, 1'b0);
        check_eq("b2b_busy_again", 64'(busy8), 64'd1);
        check_eq("b2b_done_low", 64'(done8), 64'd0);
        check_eq("b2b_s_hold", 64'(s8), 64'h07);
        finish8("b2b_second", 8'h02, 1'b0);
        tick();

        // Reset mid-run aborts asynchronously
        go8(8'h55, 8'h11, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("arst_busy", 64'(busy8), 64'd0);
        check_eq("arst_done", 64'(done8), 64'd0);
        check_eq("arst_s", 64'(s8), 64'd0);
        check_eq("arst_c", 64'(c8), 64'd0);
        #7;
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 || busy8) seen_done++;
        end
        check_eq("arst_no_done", 64'(seen_done), 64'd0);
        op8("after_rst", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0);

        // WIDTH=1: full-adder truth table
        for (int i = 0; i < 8; i++) begin
            a1 = i[2]; b1 = i[1]; cin1 = i[0]; sub1 = 1'b0; start1 = 1'b1;
            fa = 2'(i[2]) + 2'(i[1]) + 2'(i[0]);
            tick();
            start1 = 1'b0;
            check_eq($sformatf("w1_busy_%0d", i), 64'(busy1), 64'd1);
            tick();
            check_eq($sformatf("w1_done_%0d", i), 64'(done1), 64'd1);
            check_eq($sformatf("w1_busy_off_%0d", i), 64'(busy1), 64'd0);
            check_eq($sformatf("w1_s_%0d", i), 64'(s1), 64'(fa[0]));
            check_eq($sformatf("w1_c_%0d", i), 64'(c1), 64'(fa[1]));
            tick();
            check_eq($sformatf("w1_done_end_%0d", i), 64'(done1), 64'd0);
        end

        // WIDTH=1 subtract: 0 - 1 = 1 with borrow (c=0); 1 - 0 = 1, c=1
        a1 = 1'b0; b1 = 1'b1; cin1 = 1'b0; sub1 = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        check_eq("w1_sub01_s", 64'(s1), 64'd1);
        check_eq("w1_sub01_c", 64'(c1), 64'd0);
        a1 = 1'b1; b1 = 1'b0; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        check_eq("w1_sub10_s", 64'(s1), 64'd1);
        check_eq("w1_sub10_c", 64'(c1), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
